// File: rtl/mem_line_responder_pkg.sv
// rtl/mem_line_responder_pkg.sv - shared types and constants for the cache-line memory responder
package mem_line_responder_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // One in-flight transaction; the line index lives beside it because its width is a parameter.
    typedef struct packed {
        port_t             port;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } txn_t;

endpackage

// File: rtl/mem_line_responder_if.sv
// rtl/mem_line_responder_if.sv - one cache-side request/response port of the line memory
interface mem_line_responder_if;
    import mem_line_responder_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_line_responder_array.sv
// rtl/mem_line_responder_array.sv - single-port line store, combinational read, no reset
module mem_line_responder_array
    import mem_line_responder_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] lines [2**IDX_W];

    // Commit a whole line when the responder says so; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            lines[addr] <= wdata;
        end
    end

    assign rdata = lines[addr];

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency line memory serving I (read-only) and D (read/write) ports
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int IDX_W   = 10,
    parameter int LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 proc_reset,
    mem_line_responder_if.slave  port_i,
    mem_line_responder_if.slave  port_d
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    port_t             last_grant_q;
    port_t             grant_port;
    txn_t              txn_q, txn_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              req_i, req_d, accept, grant_d;
    logic              array_we;
    logic [LINE_W-1:0] array_rdata;
    logic              rsp_next;
    logic              ready_i_d, ready_d_d, ready_i_q, ready_d_q;
    logic [LINE_W-1:0] rdata_i_d, rdata_d_d, rdata_i_q, rdata_d_q;
    logic              unused_bits;

    assign req_i  = port_i.mem_read;
    assign req_d  = port_d.mem_read | port_d.mem_write;
    assign accept = (state_q == ST_IDLE) && (req_i || req_d);

    // D wins when it is alone or when I had the previous grant (round-robin on ties).
    assign grant_d    = req_d && (!req_i || (last_grant_q == PORT_I));
    assign grant_port = grant_d ? PORT_D : PORT_I;

    // Writes land on the RESP edge; a reset on that edge cancels the commit.
    assign array_we = (state_q == ST_RESP) && txn_q.write && !proc_reset;

    // The I port cannot write, and address bits above the index simply alias.
    assign unused_bits = ^{port_i.mem_write, port_i.mem_wdata,
                           port_i.mem_addr[ADDR_W-1:IDX_W], port_d.mem_addr[ADDR_W-1:IDX_W]};

    mem_line_responder_array #(.IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (idx_d),
        .wdata (txn_q.wdata),
        .rdata (array_rdata)
    );

    // Capture the granted port's request; a D request with write high is a write.
    always_comb begin
        txn_d = txn_q;
        idx_d = idx_q;
        if (accept) begin
            txn_d.port  = grant_port;
            txn_d.write = grant_d && port_d.mem_write;
            txn_d.wdata = port_d.mem_wdata;
            idx_d       = grant_d ? port_d.mem_addr[IDX_W-1:0] : port_i.mem_addr[IDX_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: request lines are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: next-cycle ready/rdata for the port being answered; writes return zero data.
    always_comb begin
        rsp_next  = (state_d == ST_RESP);
        ready_i_d = rsp_next && (txn_d.port == PORT_I);
        ready_d_d = rsp_next && (txn_d.port == PORT_D);
        rdata_i_d = '0;
        rdata_d_d = '0;
        if (ready_i_d && !txn_d.write) begin
            rdata_i_d = array_rdata;
        end
        if (ready_d_d && !txn_d.write) begin
            rdata_d_d = array_rdata;
        end
    end

    // Latency counter, transaction latch, arbiter history and registered outputs.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            cnt_q        <= '0;
            last_grant_q <= PORT_I;
            txn_q        <= '0;
            idx_q        <= '0;
            ready_i_q    <= 1'b0;
            ready_d_q    <= 1'b0;
            rdata_i_q    <= '0;
            rdata_d_q    <= '0;
        end else begin
            txn_q     <= txn_d;
            idx_q     <= idx_d;
            ready_i_q <= ready_i_d;
            ready_d_q <= ready_d_d;
            rdata_i_q <= rdata_i_d;
            rdata_d_q <= rdata_d_d;
            if (accept) begin
                cnt_q        <= CNT_W'(LATENCY - 1);
                last_grant_q <= grant_port;
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign port_i.mem_ready = ready_i_q;
    assign port_i.mem_rdata = rdata_i_q;
    assign port_d.mem_ready = ready_d_q;
    assign port_d.mem_rdata = rdata_d_q;

endmodule
